pipelined_prefix_adder: RTL
===========================

// Module: pipelined_prefix_adder
// PURPOSE
//   Parametrised Kogge-Stone parallel-prefix adder/subtractor with a configurable pipeline
//   and valid/ready handshakes on input and output.
//   Carry-in is folded in as a prefix position below bit 0 (g=cin, p=0).
//   Pre (xor/and), black/grey prefix cells and post-xor structure are unchanged from the
//   4-bit combinational adder. Pipeline registers are inserted every PIPE_EVERY prefix levels.
//   Sits in the datapath as a drop-in streaming arithmetic unit with one result per cycle.
// PARAMETERS
//   WIDTH       16  operand width, >= 2; L = clog2(WIDTH) prefix levels
//   PIPE_EVERY  2   prefix levels per pipeline stage, >= 1
//   TAG_W       4   width of sideband tag passed through unchanged, >= 1
//   Derived: LAT = ceil(L / PIPE_EVERY); minimum 1
// PORTS
//   clk        in   1        clock, all flops rising edge
//   rst        in   1        reset, asynchronous, active-high
//   in_valid   in   1        operands valid
//   in_ready   out  1        block can accept operands this cycle
//   in_a       in   WIDTH    operand A
//   in_b       in   WIDTH    operand B
//   in_cin     in   1        carry-in (borrow-in when in_sub=1)
//   in_sub     in   1        1 = subtract: A + ~B + (cin ^ 1)
//   in_tag     in   TAG_W    sideband tag
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_sum    out  WIDTH    sum / difference
//   out_cout   out  1        carry out of MSB
//   out_ovf    out  1        signed overflow = carry into MSB ^ out_cout
//   out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//   - Operand conditioning at input:
//     - b_eff = in_b ^ {WIDTH{in_sub}}, c_eff = in_cin ^ in_sub.
//     - in_sub=1, in_cin=0 gives A-B. in_sub=1, in_cin=1 gives A-B-1.
//   - Prefix network: level k (1..L) combines position i with i-2^(k-1).
//     - Positions whose span already reaches cin use grey cells; all others use black cells.
//     - Positions with i < 2^(k-1) pass through.
//   - Register boundaries: a stage boundary follows every PIPE_EVERY-th level.
//     - The final group, including post-xor, cout and ovf, ends in the output register.
//     - Group-local p/g, operand p bits, valid and tag travel together in each stage register.
//   - Latency: handshake accepted at edge t (in_valid & in_ready) -> out_valid=1 with the
//     result after edge t+LAT-1 when no stall occurs.
//   - Throughput: 1 result per cycle.
//   - Flow control is a global stall:
//     - adv = !out_valid | out_ready, and in_ready = adv (combinational).
//     - When adv=0 every stage register, including valid bits, holds.
//     - When adv=1 all stages shift by one; a stage with no incoming transfer loads valid=0.
//   - Output data stays stable while out_valid & !out_ready.
//   - Results leave in acceptance order; none are dropped or duplicated.
//   - Bubbles do not collapse while stalled. Bubbles advance only when adv=1.
//   - Reset (asynchronous, any time, including mid-operation):
//     - All stage valid bits clear, so out_valid=0 and in-flight items are discarded.
//     - out_sum, out_cout, out_ovf and out_tag are 0.
//     - in_ready=1 during and after reset.
//   - Width rules: WIDTH not a power of two uses L = clog2(WIDTH).
//     Prefix spans past bit 0 clamp at the cin position.
//   - out_cout and out_ovf are computed in the same stage as out_sum. They are never
//     one cycle early or late.
// TESTING  (WIDTH=16, PIPE_EVERY=2, so LAT=2)
//   1. Reset: assert rst -> out_valid=0, out_sum=0, in_ready=1; release, idle -> stays so.
//   2. Add carry chain: A=FFFF, B=0001, cin=0 -> sum=0000, cout=1, ovf=0.
//      out_valid high exactly after edge t+1.
//   3. Signed overflow, add: A=7FFF, B=0001 -> sum=8000, cout=0, ovf=1.
//   4. Subtract: A=8000, B=0001, sub=1, cin=0 -> sum=7FFF, cout=1, ovf=1.
//      Same with cin=1 -> sum=7FFE.
//   5. Streaming: 200 random ops with random in_valid and out_ready -> in-order results
//      matching A±B, tags intact. in_ready=0 exactly when out_valid & !out_ready.
//   6. Reset mid-flight with 2 ops in flight -> out_valid drops immediately; nothing emitted
//      after release. Also sweep WIDTH=4/PIPE_EVERY=1 exhaustively (LAT=2) and
//      WIDTH=24/PIPE_EVERY=3 (LAT=2) randomly.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone parallel-prefix adder/subtractor, streaming, one result per cycle.
// Latency: LAT = ceil(clog2(WIDTH)/PIPE_EVERY) cycles from accepting operands to the registered result.
// Backpressure: global stall. The whole pipe holds when out_valid & !out_ready, and in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready             operand handshake (in_a, in_b, in_cin, in_sub, in_tag)
//   out_valid/out_ready           result handshake (out_sum, out_cout, out_ovf, out_tag)
//
// Prefix positions: index 0 holds the carry-in (g=cin, p=0), and index j>0 holds operand bit j-1.
// After the last level, G[j] is the carry into bit j. Carry-out is formed from the top bit's own
// g/p and the carry into it, so WIDTH positions and clog2(WIDTH) levels are enough.
module pipelined_prefix_adder #(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L    = $clog2(WIDTH);
    localparam int LAT  = (L + PIPE_EVERY - 1) / PIPE_EVERY;
    // Number of inter-stage registers (the output register is separate).
    // Kept at least 1 so that the array is always legal.
    localparam int NREG = (LAT > 1) ? LAT - 1 : 1;

    // Everything that travels between prefix groups.
    // g/p is the group-local prefix state. pb is the per-bit propagate needed by the post-xor.
    // gt is the top bit's generate, which is needed for the carry-out.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] pb;
        logic             gt;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } stage_t;

    logic adv;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] pb_in;
    logic [WIDTH-1:0] gb_in;
    logic             c_eff;
    stage_t           cond;

    stage_t stg_in [LAT];   // input to each prefix group
    stage_t pipe_d [LAT];   // output of each prefix group (next state of its boundary register)
    stage_t pipe_q [NREG];  // boundary registers between groups

    logic [WIDTH-1:0] carry;
    logic             out_vld_d;
    logic [WIDTH-1:0] out_sum_d;
    logic             out_cout_d;
    logic             out_ovf_d;
    logic [TAG_W-1:0] out_tag_d;

    logic             out_vld_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    // A stall freezes every stage at once. A slot holding a bubble is not refilled while
    // the output is blocked, so in_ready follows the output register only.
    assign adv      = !out_vld_q | out_ready;
    assign in_ready = adv;

    // Operand conditioning.
    // Subtraction is A + ~B + 1, and the incoming cin acts as an active-low borrow.
    always_comb begin
        b_eff    = in_b ^ {WIDTH{in_sub}};
        c_eff    = in_cin ^ in_sub;
        pb_in    = in_a ^ b_eff;
        gb_in    = in_a & b_eff;
        cond     = '0;
        cond.vld = in_valid;
        cond.tag = in_tag;
        cond.pb  = pb_in;
        cond.gt  = gb_in[WIDTH-1];
        cond.g   = {gb_in[WIDTH-2:0], c_eff};
        cond.p   = {pb_in[WIDTH-2:0], 1'b0};
    end

    // One prefix group per pipeline stage. Group s evaluates levels K_LO..K_HI.
    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int K_LO = s * PIPE_EVERY + 1;
        localparam int K_HI = ((s + 1) * PIPE_EVERY < L) ? (s + 1) * PIPE_EVERY : L;

        if (s == 0) begin : g_src_in
            assign stg_in[s] = cond;
        end else begin : g_src_reg
            assign stg_in[s] = pipe_q[s-1];
        end

        logic [WIDTH-1:0] g_v;
        logic [WIDTH-1:0] p_v;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;

        always_comb begin
            g_v = stg_in[s].g;
            p_v = stg_in[s].p;
            g_n = g_v;
            p_n = p_v;
            for (int k = K_LO; k <= K_HI; k++) begin
                g_n = g_v;
                p_n = p_v;
                for (int j = 0; j < WIDTH; j++) begin
                    // Positions below the level distance already reach the carry-in and pass through.
                    if (j >= (1 << (k - 1))) begin
                        if (j < (2 << (k - 1))) begin
                            // Grey cell. The partner's span already includes the carry-in,
                            // so the result is a final carry and its propagate is dead.
                            g_n[j] = g_v[j] | (p_v[j] & g_v[j - (1 << (k - 1))]);
                            p_n[j] = 1'b0;
                        end else begin
                            // Black cell.
                            g_n[j] = g_v[j] | (p_v[j] & g_v[j - (1 << (k - 1))]);
                            p_n[j] = p_v[j] & p_v[j - (1 << (k - 1))];
                        end
                    end
                end
                g_v = g_n;
                p_v = p_n;
            end
            pipe_d[s]   = stg_in[s];
            pipe_d[s].g = g_v;
            pipe_d[s].p = p_v;
        end
    end

    // Post-xor, carry-out and overflow are formed in the last group.
    // They land in the output register together with the sum.
    always_comb begin
        carry      = pipe_d[LAT-1].g;
        out_vld_d  = pipe_d[LAT-1].vld;
        out_tag_d  = pipe_d[LAT-1].tag;
        out_sum_d  = pipe_d[LAT-1].pb ^ carry;
        out_cout_d = pipe_d[LAT-1].gt | (pipe_d[LAT-1].pb[WIDTH-1] & carry[WIDTH-1]);
        out_ovf_d  = carry[WIDTH-1] ^ out_cout_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NREG; s++) begin
                pipe_q[s] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_tag_q  <= '0;
        end else if (adv) begin
            // Valid bits shift together with the data, so a bubble stays a bubble.
            for (int s = 0; s < LAT - 1; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
            out_vld_q  <= out_vld_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_tag   = out_tag_q;

endmodule
